// File: rtl/bpsk_pkg.sv
// ---------------------------------------------------------------------------
// bpsk_pkg
//   Shared types and helpers for the BPSK frame controller.
//   - state_t     : controller FSM states
//   - SYM_ZERO    : the only soft-symbol pair that decides to a 0 bit
//   - is_erasure  : flags ambiguous symbol pairs (2'b00 / 2'b11)
//   - decide_bit  : hard decision for one symbol pair, identical to the
//                   combinational demod stage
// ---------------------------------------------------------------------------
package bpsk_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  localparam logic [1:0] SYM_ZERO = 2'b01;

  function automatic logic is_erasure(input logic [1:0] sym);
    return (sym == 2'b00) || (sym == 2'b11);
  endfunction

  // Everything that is not a clean "01" decides to 1, erasures included.
  function automatic logic decide_bit(input logic [1:0] sym);
    return (sym != SYM_ZERO);
  endfunction

endpackage

// File: rtl/bpsk_sym_collector.sv
// ---------------------------------------------------------------------------
// bpsk_sym_collector
//   Indexed 2N-bit symbol store with per-bit hard decision and a saturating
//   erasure counter for the word being assembled.
// Ports
//   clk, rst    : clock, asynchronous active-high reset
//   wr_en       : write sym_in into slot wr_idx this cycle
//   first       : this write starts a new word (erasure count restarts)
//   wr_idx      : slot index, 0 = first symbol of the word
//   sym_in      : soft-symbol pair
//   bits_next   : decided word as it will look after this cycle's write
//   erase_cnt   : erasures seen in the current word (saturates at N)
// ---------------------------------------------------------------------------
module bpsk_sym_collector
  import bpsk_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   first,
  input  logic [$clog2(N+1)-1:0] wr_idx,
  input  logic [1:0]             sym_in,
  output logic [N-1:0]           bits_next,
  output logic [$clog2(N+1)-1:0] erase_cnt
);

  localparam int CW = $clog2(N + 1);

  logic [2*N-1:0] store_q;
  logic [2*N-1:0] store_d;
  logic [CW-1:0]  erase_q;
  logic [CW-1:0]  erase_d;
  logic [CW-1:0]  erase_base;

  // Decisions are taken on the post-write view so the top can capture the
  // complete word on the same edge that accepts the last symbol.
  for (genvar gi = 0; gi < N; gi++) begin : g_slot
    logic slot_wr;
    assign slot_wr                = wr_en && (wr_idx == CW'(gi));
    assign store_d[2*gi +: 2]     = slot_wr ? sym_in : store_q[2*gi +: 2];
    assign bits_next[gi]          = decide_bit(store_d[2*gi +: 2]);
  end

  always_comb begin
    erase_base = first ? '0 : erase_q;
    erase_d    = erase_q;
    if (wr_en) begin
      erase_d = erase_base;
      if (is_erasure(sym_in) && (erase_base != CW'(N))) begin
        erase_d = erase_base + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      store_q <= '0;
      erase_q <= '0;
    end else begin
      store_q <= store_d;
      erase_q <= erase_d;
    end
  end

  assign erase_cnt = erase_q;

endmodule

// File: rtl/bpsk_frame_ctrl.sv
// ---------------------------------------------------------------------------
// bpsk_frame_ctrl
//   Frames BPSK soft-symbol pairs into N-bit data words between the audio
//   symbol slicer and the FEC decoder. Handles valid/ready flow control on
//   both sides, erasure counting and an inter-symbol timeout.
// Ports
//   clk, rst     : clock, asynchronous active-high reset
//   sym_in       : soft-symbol pair from slicer
//   sym_valid    : sym_in valid
//   sym_ready    : symbol can be accepted (low only while a word is held)
//   data_out     : decided word, bit k from k-th symbol of the word
//   data_valid   : data_out / erase_cnt valid, held until data_ready
//   data_ready   : downstream accepts the word
//   erase_cnt    : erasure count of the presented word
//   timeout_err  : one-cycle pulse when a partial word is aborted
//   busy         : controller is not idle
// ---------------------------------------------------------------------------
module bpsk_frame_ctrl
  import bpsk_pkg::*;
#(
  parameter int N       = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             sym_in,
  input  logic                   sym_valid,
  output logic                   sym_ready,
  output logic [N-1:0]           data_out,
  output logic                   data_valid,
  input  logic                   data_ready,
  output logic [$clog2(N+1)-1:0] erase_cnt,
  output logic                   timeout_err,
  output logic                   busy
);

  localparam int CW = $clog2(N + 1);
  localparam int GW = $clog2(TIMEOUT + 1);

  state_t         state_q, state_d;
  logic [CW-1:0]  sym_cnt_q, sym_cnt_d;
  logic [GW-1:0]  gap_cnt_q, gap_cnt_d;
  logic [N-1:0]   data_out_q, data_out_d;
  logic           data_valid_q, data_valid_d;
  logic           timeout_err_q, timeout_err_d;

  logic           xfer;
  logic           first_sym;
  logic [CW-1:0]  wr_idx;
  logic [N-1:0]   bits_next;

  // Ready only depends on state, so a symbol presented during HOLD simply
  // waits upstream; nothing is dropped.
  assign sym_ready = (state_q != HOLD);
  assign xfer      = sym_valid && sym_ready;
  assign first_sym = (state_q == IDLE);
  assign wr_idx    = first_sym ? '0 : sym_cnt_q;

  bpsk_sym_collector #(
    .N (N)
  ) u_collector (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (xfer),
    .first     (first_sym),
    .wr_idx    (wr_idx),
    .sym_in    (sym_in),
    .bits_next (bits_next),
    .erase_cnt (erase_cnt)
  );

  always_comb begin
    state_d       = state_q;
    sym_cnt_d     = sym_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    data_out_d    = data_out_q;
    data_valid_d  = data_valid_q;
    timeout_err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          sym_cnt_d = CW'(1);
          gap_cnt_d = '0;
          if (N == 1) begin
            state_d      = HOLD;
            data_out_d   = bits_next;
            data_valid_d = 1'b1;
          end else begin
            state_d = COLLECT;
          end
        end
      end

      COLLECT: begin
        if (xfer) begin
          gap_cnt_d = '0;
          if (sym_cnt_q == CW'(N - 1)) begin
            state_d      = HOLD;
            sym_cnt_d    = '0;
            data_out_d   = bits_next;
            data_valid_d = 1'b1;
          end else begin
            sym_cnt_d = sym_cnt_q + CW'(1);
          end
        end else if (gap_cnt_q == GW'(TIMEOUT - 1)) begin
          // This idle cycle brings the gap to TIMEOUT: abort the word.
          // data_out keeps the last delivered word.
          state_d       = IDLE;
          sym_cnt_d     = '0;
          gap_cnt_d     = '0;
          timeout_err_d = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end

      HOLD: begin
        if (data_ready) begin
          state_d      = IDLE;
          data_valid_d = 1'b0;
        end
      end

      default: begin
        state_d      = IDLE;
        sym_cnt_d    = '0;
        gap_cnt_d    = '0;
        data_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      sym_cnt_q     <= '0;
      gap_cnt_q     <= '0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sym_cnt_q     <= sym_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign timeout_err = timeout_err_q;
  assign busy        = (state_q != IDLE);

endmodule
